// File: rtl/pet2001_linedoubler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pet2001_linedoubler                                                  |
// | Re-emits each 15.7 kHz PET video line twice at double pixel rate.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pet2001_linedoubler #(
    parameter int LINE_LEN  = 448,
    parameter int ACT_START = 90,
    parameter int ACT_LEN   = 320,
    parameter int HS_WIDTH  = 54
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce_7mp,
    input  logic ce_7mn,
    input  logic enable,
    input  logic pix,
    input  logic HSync,
    input  logic VSync,
    input  logic VBlank,
    output logic vga_pix,
    output logic vga_hs,
    output logic vga_vs,
    output logic vga_hblank,
    output logic vga_vblank,
    output logic vga_second
);

    localparam int c_XW = $clog2(LINE_LEN + 1);
    localparam int c_AW = $clog2(LINE_LEN);

    localparam logic [c_XW-1:0] c_LEN    = c_XW'(LINE_LEN);
    localparam logic [c_XW-1:0] c_LAST   = c_XW'(LINE_LEN - 1);
    localparam logic [c_XW-1:0] c_ONE    = c_XW'(1);
    localparam logic [c_XW-1:0] c_HS_END = c_XW'(HS_WIDTH);
    localparam logic [c_XW-1:0] c_ACT_LO = c_XW'(ACT_START);
    localparam logic [c_XW-1:0] c_ACT_HI = c_XW'(ACT_START + ACT_LEN);

    logic              r_bank [2][LINE_LEN];
    logic              r_hs_d;
    logic [c_XW-1:0]   r_in_x;
    logic [c_XW-1:0]   r_out_x;
    logic              r_wb;
    logic              r_locked;
    logic              r_vs_l;
    logic              r_vb_l;
    logic              r_copy;

    logic              w_tick;
    logic              w_ls;
    logic [c_XW-1:0]   w_cur_in;
    logic [c_XW-1:0]   w_cur;
    logic [c_AW-1:0]   w_waddr;
    logic [c_AW-1:0]   w_raddr;
    logic              w_wb;
    logic              w_rb;
    logic              w_locked;
    logic              w_wrap;
    logic              w_copy;
    logic              w_act;

    assign w_tick   = ce_7mp | ce_7mn;
    assign w_ls     = ce_7mp & HSync & ~r_hs_d;
    assign w_cur_in = w_ls ? '0 : r_in_x;
    assign w_cur    = w_ls ? '0 : r_out_x;
    assign w_waddr  = w_cur_in[c_AW-1:0];
    assign w_raddr  = w_cur[c_AW-1:0];
    // Both banks swap on the line-start tick itself, so pixel 0 of the new
    // line already lands in the fresh bank while the finished one is read.
    assign w_wb     = w_ls ? ~r_wb : r_wb;
    assign w_rb     = ~w_wb;
    assign w_locked = r_locked | w_ls;
    assign w_wrap   = (w_cur == c_LAST);
    assign w_copy   = w_ls ? 1'b0 : r_copy;
    assign w_act    = (w_cur >= c_ACT_LO) && (w_cur < c_ACT_HI);

    always_ff @(posedge clk) begin
        if (ce_7mp && (w_cur_in < c_LEN)) begin
            r_bank[w_wb][w_waddr] <= pix;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_d   <= 1'b0;
            r_in_x   <= '0;
            r_wb     <= 1'b0;
            r_locked <= 1'b0;
            r_vs_l   <= 1'b0;
            r_vb_l   <= 1'b0;
        end else if (ce_7mp) begin
            r_hs_d <= HSync;
            r_in_x <= (w_cur_in == c_LEN) ? c_LEN : w_cur_in + c_ONE;
            if (w_ls) begin
                r_wb     <= ~r_wb;
                r_locked <= 1'b1;
                r_vs_l   <= VSync;
                r_vb_l   <= VBlank;
            end
        end
    end

    // Replay position keeps running in pass-through so a re-enable resumes cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_x <= '0;
            r_copy  <= 1'b0;
        end else if (w_tick && w_locked) begin
            r_out_x <= w_wrap ? '0 : w_cur + c_ONE;
            r_copy  <= w_copy ^ w_wrap;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_pix    <= 1'b0;
            vga_hs     <= 1'b0;
            vga_vs     <= 1'b0;
            vga_hblank <= 1'b1;
            vga_vblank <= 1'b1;
            vga_second <= 1'b0;
        end else if (!enable) begin
            if (ce_7mn) begin
                vga_pix    <= pix;
                vga_hs     <= HSync;
                vga_vs     <= VSync;
                vga_hblank <= 1'b0;
                vga_vblank <= VBlank;
                vga_second <= 1'b0;
            end
        end else if (w_tick && w_locked) begin
            vga_pix    <= r_bank[w_rb][w_raddr];
            vga_hs     <= (w_cur < c_HS_END);
            vga_hblank <= ~w_act;
            vga_vs     <= w_ls ? VSync : r_vs_l;
            vga_vblank <= w_ls ? VBlank : r_vb_l;
            vga_second <= w_copy;
        end
    end

endmodule
`default_nettype wire
